// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine. Serialises 32-bit loads and
// stores into byte transfers on an 8-bit memory-controller port, assembles and
// extends load data, and forwards the writeback fields towards MEM/WB.
// Latency: non-memory ops pass through combinationally; a load/store costs one
//   request cycle, then one BUSY cycle per byte plus controller wait, then DONE.
// Backpressure: stall_req is held from the request cycle until DONE; mc_req
//   stays high until the controller has acked every byte.
// Ports:
//   clk, rst                      clock, async active-high reset
//   rd_addr_i/rd_write_i/rd_data_i writeback fields from EX/MEM
//   rd_load_i, mem_addr_i, mem_data_i, op_i, catagory_i  request from EX/MEM
//   rd_addr_o/rd_write_o/rd_data_o writeback fields to MEM/WB
//   stall_req                     hold request to the pipeline controller
//   mc_req/mc_we/mc_addr/mc_wdata  byte request to the memory controller
//   mc_ack/mc_rdata               byte completion from the memory controller
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_write_i,
  input  logic        rd_load_i,
  input  logic [31:0] rd_data_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  catagory_i,
  output logic [4:0]  rd_addr_o,
  output logic        rd_write_o,
  output logic [31:0] rd_data_o,
  output logic        stall_req,
  output logic        mc_req,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [7:0]  mc_wdata,
  input  logic        mc_ack,
  input  logic [7:0]  mc_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] buf_q, buf_d;
  logic        mc_req_q, mc_req_d;
  logic        mc_we_q, mc_we_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [7:0]  mc_wdata_q, mc_wdata_d;
  // Load flag and size code captured at the request so the DONE-cycle
  // extension does not depend on the upstream register still holding.
  logic        ld_q, ld_d;
  logic [2:0]  op_q, op_d;

  logic        mem_op;
  logic        last_byte;
  logic [1:0]  cnt_nxt;
  logic [31:0] ld_ext;

  // rd_load_i duplicates catagory_i==1, which is what the datapath keys on.
  logic unused_inputs;
  assign unused_inputs = rd_load_i;

  assign mem_op    = (catagory_i == 2'd1) || (catagory_i == 2'd2);
  assign last_byte = ({1'b0, cnt_q} == (len_q - 3'd1));
  assign cnt_nxt   = cnt_q + 2'd1;

  function automatic logic [2:0] size_len(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: size_len = 3'd1;
      3'd1, 3'd5: size_len = 3'd2;
      default:    size_len = 3'd4;  // W, and the unused codes 3/6/7
    endcase
  endfunction

  always_comb begin
    case (op_q)
      3'd0:    ld_ext = {{24{buf_q[7]}}, buf_q[7:0]};
      3'd4:    ld_ext = {24'd0, buf_q[7:0]};
      3'd1:    ld_ext = {{16{buf_q[15]}}, buf_q[15:0]};
      3'd5:    ld_ext = {16'd0, buf_q[15:0]};
      default: ld_ext = buf_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    buf_d      = buf_q;
    mc_req_d   = mc_req_q;
    mc_we_d    = mc_we_q;
    mc_addr_d  = mc_addr_q;
    mc_wdata_d = mc_wdata_q;
    ld_d       = ld_q;
    op_d       = op_q;
    stall_req  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          stall_req  = 1'b1;
          state_d    = S_BUSY;
          cnt_d      = 2'd0;
          len_d      = size_len(op_i);
          mc_req_d   = 1'b1;
          mc_we_d    = (catagory_i == 2'd2);
          mc_addr_d  = mem_addr_i;
          mc_wdata_d = mem_data_i[7:0];
          ld_d       = (catagory_i == 2'd1);
          op_d       = op_i;
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        if (mc_ack) begin
          if (!mc_we_q) begin
            buf_d[{cnt_q, 3'b000} +: 8] = mc_rdata;
          end
          if (!last_byte) begin
            cnt_d      = cnt_nxt;
            // Upstream holds during the stall, so the base address and store
            // word are re-read from the inputs rather than kept locally.
            mc_addr_d  = mem_addr_i + {30'd0, cnt_q} + 32'd1;
            mc_wdata_d = mem_data_i[{cnt_nxt, 3'b000} +: 8];
          end else begin
            mc_req_d = 1'b0;
            mc_we_d  = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Pipeline advances on this edge; the next instruction is seen in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      len_q      <= 3'd0;
      buf_q      <= 32'd0;
      mc_req_q   <= 1'b0;
      mc_we_q    <= 1'b0;
      mc_addr_q  <= 32'd0;
      mc_wdata_q <= 8'd0;
      ld_q       <= 1'b0;
      op_q       <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      buf_q      <= buf_d;
      mc_req_q   <= mc_req_d;
      mc_we_q    <= mc_we_d;
      mc_addr_q  <= mc_addr_d;
      mc_wdata_q <= mc_wdata_d;
      ld_q       <= ld_d;
      op_q       <= op_d;
    end
  end

  assign rd_addr_o  = rd_addr_i;
  assign rd_write_o = rd_write_i;
  assign rd_data_o  = (state_q == S_DONE && ld_q) ? ld_ext : rd_data_i;

  assign mc_req   = mc_req_q;
  assign mc_we    = mc_we_q;
  assign mc_addr  = mc_addr_q;
  assign mc_wdata = mc_wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns load/store requests into byte-serial transactions on the 8-bit memory-controller port, assembles and sign-/zero-extends load data, and forwards the writeback fields to MEM/WB.
- Holds the pipeline by asserting stall_req while a transfer is outstanding.

Parameters:
- None. Datapath fixed at 32-bit address/data, 8-bit memory port.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- rd_addr_i  input  5  destination register from EX/MEM
- rd_write_i  input  1  register write enable from EX/MEM
- rd_load_i  input  1  instruction is a load
- rd_data_i  input  32  ALU result from EX/MEM
- mem_addr_i  input  32  effective address
- mem_data_i  input  32  store data
- op_i  input  3  funct3 size code: 0=B, 1=H, 2=W, 4=BU, 5=HU
- catagory_i  input  2  0=none, 1=load, 2=store, 3=none
- rd_addr_o  output  5  to MEM/WB
- rd_write_o  output  1  to MEM/WB
- rd_data_o  output  32  writeback value
- stall_req  output  1  hold request to the pipeline controller
- mc_req  output  1  byte request valid
- mc_we  output  1  1=write, 0=read
- mc_addr  output  32  byte address
- mc_wdata  output  8  write byte
- mc_ack  input  1  one-cycle completion pulse; mc_rdata valid in the same cycle
- mc_rdata  input  8  read byte

Behaviour:
- FSM states:
  - IDLE: no transfer in progress.
  - BUSY: issuing and awaiting bytes.
  - DONE: one cycle presenting the result.
- Registers: state, cnt[1:0], len[2:0], buf[31:0], mc_* outputs.
- Reset (async): state=IDLE, cnt=0, buf=0, mc_req=0, mc_we=0, mc_addr=0, mc_wdata=0. Any transfer in flight is abandoned; mc_req drops immediately.
- Transfer length: len = 1 for op 0/4, 2 for op 1/5, 4 otherwise. Op codes 3, 6 and 7 are treated as W.
- IDLE, catagory_i is 1 or 2:
  - stall_req=1 combinationally in the same cycle.
  - Next edge: state=BUSY, cnt=0, mc_req=1, mc_we=(catagory_i==2), mc_addr=mem_addr_i, mc_wdata=mem_data_i[7:0].
- IDLE, catagory_i is 0 or 3: stall_req=0. Outputs pass through combinationally: rd_addr_o=rd_addr_i, rd_write_o=rd_write_i, rd_data_o=rd_data_i.
- BUSY: stall_req=1. mc_req stays high until the final ack.
  - On mc_ack with a read: buf byte[cnt] <= mc_rdata.
  - On mc_ack with cnt < len-1: cnt++, mc_addr <= mem_addr_i + cnt + 1 (mod 2^32, so 0xFFFFFFFF wraps to 0), mc_wdata <= mem_data_i byte[cnt+1].
  - On mc_ack with cnt == len-1: mc_req <= 0, mc_we <= 0, state <= DONE.
  - Without mc_ack: all registers hold.
- Back-to-back bytes: a new mc_addr/mc_wdata is presented the cycle after each ack. Minimum cost is therefore one cycle per byte plus controller latency.
- DONE:
  - stall_req=0.
  - Load: rd_data_o = extended buf. B: sign-extend buf[7]; BU: zero-extend 8 bits; H: sign-extend buf[15]; HU: zero-extend 16 bits; W: buf.
  - Store: rd_data_o = rd_data_i.
  - Next edge: state=IDLE unconditionally. The pipeline advances on that edge, so a new instruction is evaluated in IDLE on the following cycle.
- Minimum latency, load with 0-cycle-wait controller:
  - Request cycle, then len BUSY cycles, then DONE.
  - LW therefore holds the pipeline 5 cycles.
- Spurious mc_ack in IDLE or DONE is ignored.
- Misaligned addresses are legal; bytes are transferred sequentially with no alignment check.
- Upstream inputs are stable while stall_req=1 (EX/MEM register is in Hold). The block does not re-sample catagory_i or op_i during BUSY.
- A bubble (all-zero inputs) produces all-zero pass-through outputs and no memory activity.

Test Plan:
- Reset then bubble: rst pulse, all inputs 0 -> mc_req=0, stall_req=0, rd_*_o=0.
- LB at 0x00001003, ack returns 0x80 -> exactly 1 read at 0x1003; rd_data_o=0xFFFFFF80 in DONE; stall_req high 2 cycles.
- LHU at 0x10, acks return 0x34 then 0x82, ack delayed 3 cycles each -> reads at 0x10, 0x11; rd_data_o=0x00008234; stall_req held throughout, dropping only in DONE.
- SW 0xDEADBEEF at 0xFFFFFFFE -> writes EF@0xFFFFFFFE, BE@0xFFFFFFFF, AD@0x0, DE@0x1 with mc_we=1; rd_data_o=rd_data_i in DONE.
- Non-memory op, rd_data_i=0x1234, rd_write_i=1, rd_addr_i=7 -> same-cycle pass-through; stall_req=0; mc_req=0.
- rst asserted mid-LW after 2 acks -> mc_req=0 immediately; state IDLE. A following LW restarts from byte 0 at its base address.
